rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 14 +
 rtl/rf_wb_arbiter_if.sv | 43 ++++
 rtl/rf_wb_arbiter_rr_arbiter.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 73 +++++++
 tb/tb_rf_wb_arbiter.sv | 135 +++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Requester indices match the bit positions of the request vectors.
package rf_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREQ       = 3;
    localparam int IDX_W      = 2;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_CSR = 2;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bus plus the registered register-file write port.
// master = requester side, slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int XLEN = rf_wb_arbiter_pkg::XLEN,
    parameter int NREQ = rf_wb_arbiter_pkg::NREQ
);
    import rf_wb_arbiter_pkg::*;

    logic                       hold;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [REG_ADDR_W*NREQ-1:0] req_addr;
    logic [XLEN*NREQ-1:0]       req_data;
    logic                       rf_we;
    logic [REG_ADDR_W-1:0]      rf_rd_addr;
    logic [XLEN-1:0]            rf_rd_data;
    logic [IDX_W-1:0]           last_grant;

    modport master (
        output hold,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  rf_we,
        input  rf_rd_addr,
        input  rf_rd_data,
        input  last_grant
    );

    modport slave (
        input  hold,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output rf_we,
        output rf_rd_addr,
        output rf_rd_data,
        output last_grant
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin selector: search starts one past the pointer, first valid wins.
// Out-of-range pointers are treated as the last requester.
module rr_arbiter #(
    parameter int NREQ = rf_wb_arbiter_pkg::NREQ
) (
    input  logic [NREQ-1:0]                       i_valid,
    input  logic                                  i_hold,
    input  logic [rf_wb_arbiter_pkg::IDX_W-1:0]   i_ptr,
    output logic [NREQ-1:0]                       o_grant,
    output logic [rf_wb_arbiter_pkg::IDX_W-1:0]   o_idx
);
    import rf_wb_arbiter_pkg::*;

    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_cand [NREQ];
    logic             w_found;

    assign w_base = (int'(i_ptr) >= NREQ) ? IDX_W'(NREQ - 1) : i_ptr;

    // w_cand[k] is the requester visited k-th in priority order
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign w_cand[k] = IDX_W'((int'(w_base) + k + 1) % NREQ);
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        if (!i_hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && i_valid[w_cand[k]]) begin
                    o_grant[w_cand[k]] = 1'b1;
                    o_idx              = w_cand[k];
                    w_found            = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle and registers its
// write onto the register-file port; writes to x0 are consumed silently.
module rf_wb_arbiter #(
    parameter int XLEN = rf_wb_arbiter_pkg::XLEN,
    parameter int NREQ = rf_wb_arbiter_pkg::NREQ
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    import rf_wb_arbiter_pkg::*;

    logic [NREQ-1:0]       w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_block;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;
    logic [IDX_W-1:0]      r_last;

    // reset blocks grants the same way hold does
    assign w_block = bus.hold | rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_valid (bus.req_valid),
        .i_hold  (w_block),
        .i_ptr   (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_xfer = |w_grant;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_addr |= bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_data |= bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_last <= IDX_W'(NREQ - 1);
        end else if (w_xfer) begin
            r_we   <= (w_addr != '0);
            r_addr <= w_addr;
            r_data <= w_data;
            r_last <= w_idx;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rf_we      = r_we;
    assign bus.rf_rd_addr = r_addr;
    assign bus.rf_rd_data = r_data;
    assign bus.last_grant = r_last;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin order, x0 drop,
// same-address ordering, hold and mid-stream reset.
module tb_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    rf_wb_arbiter_if #(.XLEN(32), .NREQ(3)) bus ();

    rf_wb_arbiter #(
        .XLEN (32),
        .NREQ (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2);
        bus.req_addr = {a2, a1, a0};
        bus.req_data = {d2, d1, d0};
    endtask

    task automatic cyc(input string tag, input logic [2:0] v,
                       input logic h, input logic r,
                       input logic [2:0] exp_rdy);
        bus.req_valid = v;
        bus.hold      = h;
        rst           = r;
        #1;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic we,
                           input logic [4:0] a, input logic [31:0] d,
                           input logic [1:0] lg);
        chk({tag, ".we"},   32'(bus.rf_we),      32'(we));
        chk({tag, ".addr"}, 32'(bus.rf_rd_addr), 32'(a));
        chk({tag, ".data"}, bus.rf_rd_data,      d);
        chk({tag, ".last"}, 32'(bus.last_grant), 32'(lg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.hold      = 1'b0;
        bus.req_valid = 3'b111;
        set_fields(5'd1, 32'h101, 5'd2, 32'h202, 5'd3, 32'h303);
        @(posedge clk);
        #1;

        cyc("rst", 3'b111, 1'b0, 1'b1, 3'b000);
        chk_out("rst", 1'b0, 5'd0, 32'h0, 2'd2);

        set_fields(5'd5, 32'hAA, 5'd2, 32'h202, 5'd3, 32'h303);
        cyc("alu", 3'b001, 1'b0, 1'b0, 3'b001);
        chk_out("alu", 1'b1, 5'd5, 32'hAA, 2'd0);

        cyc("rst2", 3'b000, 1'b0, 1'b1, 3'b000);
        chk_out("rst2", 1'b0, 5'd0, 32'h0, 2'd2);

        set_fields(5'd1, 32'h101, 5'd2, 32'h202, 5'd3, 32'h303);
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 3;
            cyc($sformatf("rr%0d", i), 3'b111, 1'b0, 1'b0, 3'(1 << g));
            chk_out($sformatf("rr%0d", i), 1'b1, 5'(g + 1),
                    32'h101 * 32'(g + 1), 2'(g));
        end

        set_fields(5'd1, 32'h101, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h303);
        cyc("x0", 3'b010, 1'b0, 1'b0, 3'b010);
        chk_out("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 2'd1);

        set_fields(5'd9, 32'h99, 5'd2, 32'h202, 5'd3, 32'h303);
        cyc("pre", 3'b001, 1'b0, 1'b0, 3'b001);
        chk_out("pre", 1'b1, 5'd9, 32'h99, 2'd0);

        set_fields(5'd7, 32'h11, 5'd7, 32'h22, 5'd3, 32'h303);
        cyc("same1", 3'b011, 1'b0, 1'b0, 3'b010);
        chk_out("same1", 1'b1, 5'd7, 32'h22, 2'd1);
        cyc("same2", 3'b001, 1'b0, 1'b0, 3'b001);
        chk_out("same2", 1'b1, 5'd7, 32'h11, 2'd0);

        set_fields(5'd1, 32'h101, 5'd2, 32'h202, 5'd3, 32'h303);
        bus.req_valid = 3'b111;
        bus.hold      = 1'b1;
        #1;
        chk("hold.pending_we", 32'(bus.rf_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("hold%0d", i), 3'b111, 1'b1, 1'b0, 3'b000);
            chk_out($sformatf("hold%0d", i), 1'b0, 5'd7, 32'h11, 2'd0);
        end
        cyc("resume", 3'b111, 1'b0, 1'b0, 3'b010);
        chk_out("resume", 1'b1, 5'd2, 32'h202, 2'd1);

        cyc("midrst", 3'b111, 1'b0, 1'b1, 3'b000);
        chk_out("midrst", 1'b0, 5'd0, 32'h0, 2'd2);
        cyc("postrst", 3'b111, 1'b0, 1'b0, 3'b001);
        chk_out("postrst", 1'b1, 5'd1, 32'h101, 2'd0);

        cyc("idle", 3'b000, 1'b0, 1'b0, 3'b000);
        chk_out("idle", 1'b0, 5'd1, 32'h101, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
